// File: rtl/shift_engine.sv
// Multi-cycle N-bit shifter: logical, arithmetic or rotate, one bit per clock for amt cycles.
// Latency amt+1 edges from start to done. New requests are ignored while busy.
module shift_engine #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          ck,
    input  logic          rn,
    input  logic          load,
    input  logic [N-1:0]  pinp,
    input  logic          start,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          linp,
    input  logic          rinp,
    output logic [N-1:0]  out,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_dir;
    logic [1:0]    r_mode;
    logic [N-1:0]  r_out;
    logic          r_sout;
    logic          r_busy;
    logic          r_done;

    logic [N-1:0]  w_next;
    logic          w_bit;
    logic          w_last;

    // One single-bit step of the captured operation; reserved mode 11 falls into the logical case.
    always_comb begin
        w_next = r_out;
        w_bit  = 1'b0;
        if (r_dir) begin
            w_bit = r_out[0];
            case (r_mode)
                2'b01:   w_next = {r_out[N-1], r_out[N-1:1]};
                2'b10:   w_next = {r_out[0], r_out[N-1:1]};
                default: w_next = {linp, r_out[N-1:1]};
            endcase
        end else begin
            w_bit = r_out[N-1];
            case (r_mode)
                2'b01:   w_next = {r_out[N-2:0], 1'b0};
                2'b10:   w_next = {r_out[N-2:0], r_out[N-1]};
                default: w_next = {r_out[N-2:0], rinp};
            endcase
        end
    end

    assign w_last = (r_cnt == {{(AW-1){1'b0}}, 1'b1});

    always_ff @(posedge ck) begin
        if (!rn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 2'b00;
            r_out   <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_out <= pinp;
                    end else if (start) begin
                        if (amt == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dir   <= dir;
                            r_mode  <= mode;
                            r_cnt   <= amt;
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_out  <= w_next;
                    r_sout <= w_bit;
                    r_cnt  <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out  = r_out;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
